// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared types, op codes, address fields and timing defaults for dram_cmd_issuer
package dram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_type_e;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_PRE    = 3'd2;
  localparam state_t ST_ACT    = 3'd3;
  localparam state_t ST_COL    = 3'd4;
  localparam state_t ST_DATA   = 3'd5;
  localparam state_t ST_CLOSE  = 3'd6;

  localparam logic [1:0] OP_READ     = 2'd0;
  localparam logic [1:0] OP_WRITE    = 2'd1;
  localparam logic [1:0] OP_FETCH    = 2'd2;
  localparam logic [1:0] OP_READ_ALT = 2'd3;

  localparam int ADDR_W  = 33;
  localparam int BG_LSB  = 6;
  localparam int BG_W    = 2;
  localparam int BA_LSB  = 8;
  localparam int BA_W    = 2;
  localparam int COL_LSB = 10;
  localparam int COL_W   = 8;
  localparam int ROW_LSB = 18;
  localparam int ROW_W   = 15;

  localparam int DEF_T_RCD   = 24;
  localparam int DEF_T_RP    = 24;
  localparam int DEF_T_RAS   = 52;
  localparam int DEF_T_CL    = 24;
  localparam int DEF_T_CWL   = 20;
  localparam int DEF_T_BURST = 4;
  localparam int DEF_CNT_W   = 7;

  function automatic logic is_write(input logic [1:0] op);
    return op == OP_WRITE;
  endfunction

endpackage

// File: rtl/dram_bank_table.sv
// rtl/dram_bank_table.sv - open flag, open row and saturating timer for each of the 16 banks
module dram_bank_table import dram_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_RP  = DEF_T_RP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       idx,
  input  logic             act_en,
  input  logic             pre_en,
  input  logic [ROW_W-1:0] act_row,
  output logic             bk_open,
  output logic [ROW_W-1:0] bk_row,
  output logic             bk_zero
);

  // Stored as V-1 so a load on cycle C reads zero on cycle C+V.
  localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);

  logic [15:0]                  open_q, open_d;
  logic [15:0][ROW_W-1:0]       row_q, row_d;
  logic [15:0][CNT_W-1:0]       cnt_q, cnt_d;

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - CNT_W'(1);
      if (idx == 4'(i)) begin
        if (act_en) begin
          open_d[i] = 1'b1;
          row_d[i]  = act_row;
          cnt_d[i]  = LD_RAS;
        end else if (pre_en) begin
          open_d[i] = 1'b0;
          cnt_d[i]  = LD_RP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= '0;
      row_q  <= '0;
      cnt_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bk_open = open_q[idx];
  assign bk_row  = row_q[idx];
  assign bk_zero = (cnt_q[idx] == '0);

endmodule

// File: rtl/dram_cmd_issuer.sv
// rtl/dram_cmd_issuer.sv - DDR4 PRE/ACT/RD/WR sequencer for one queued request at a time
// OPEN_PAGE_EN defined keeps rows open; undefined closes the row (PRE) before completing.
module dram_cmd_issuer import dram_pkg::*; #(
  parameter int T_RCD   = DEF_T_RCD,
  parameter int T_RP    = DEF_T_RP,
  parameter int T_RAS   = DEF_T_RAS,
  parameter int T_CL    = DEF_T_CL,
  parameter int T_CWL   = DEF_T_CWL,
  parameter int T_BURST = DEF_T_BURST,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [32:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [14:0] cmd_row,
  output logic [7:0]  cmd_col,
  output logic        done_valid,
  output logic [1:0]  done_op
);

  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(T_CL + T_BURST - 1);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(T_CWL + T_BURST - 1);

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [1:0]         op_q, op_d;
  logic [BG_W-1:0]    bg_q, bg_d;
  logic [BA_W-1:0]    ba_q, ba_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               wait_zero;
  logic               act_en, pre_en;
  logic               bk_open, bk_zero;
  logic [ROW_W-1:0]   bk_row;
  logic               unused_addr;

  assign unused_addr = ^req_addr[BG_LSB-1:0];
  assign wait_zero   = (wait_q == '0);
  assign req_ready   = ready_q;

  dram_bank_table #(.CNT_W(CNT_W), .T_RAS(T_RAS), .T_RP(T_RP)) u_bank_table (
    .clk     (clk),
    .rst     (rst),
    .idx     ({bg_q, ba_q}),
    .act_en  (act_en),
    .pre_en  (pre_en),
    .act_row (row_q),
    .bk_open (bk_open),
    .bk_row  (bk_row),
    .bk_zero (bk_zero)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bg_d       = bg_q;
    ba_d       = ba_q;
    row_d      = row_q;
    col_d      = col_q;
    wait_d     = wait_zero ? '0 : wait_q - CNT_W'(1);
    act_en     = 1'b0;
    pre_en     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_type   = CMD_NOP;
    cmd_bg     = '0;
    cmd_ba     = '0;
    cmd_row    = '0;
    cmd_col    = '0;
    done_valid = 1'b0;
    done_op    = '0;
    case (state_q)
      ST_IDLE: if (req_valid && ready_q) begin
        op_d    = req_op;
        bg_d    = req_addr[BG_LSB +: BG_W];
        ba_d    = req_addr[BA_LSB +: BA_W];
        row_d   = req_addr[ROW_LSB +: ROW_W];
        col_d   = req_addr[COL_LSB +: COL_W];
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (bk_open && bk_row == row_q) state_d = ST_COL;
        else if (bk_open)               state_d = ST_PRE;
        else                            state_d = ST_ACT;
      end
      ST_PRE: if (wait_zero && bk_zero) begin
        pre_en    = 1'b1;
        cmd_valid = 1'b1;
        cmd_type  = CMD_PRE;
        cmd_bg    = bg_q;
        cmd_ba    = ba_q;
        wait_d    = '0;
        state_d   = ST_ACT;
      end
      ST_ACT: if (wait_zero && bk_zero) begin
        act_en    = 1'b1;
        cmd_valid = 1'b1;
        cmd_type  = CMD_ACT;
        cmd_bg    = bg_q;
        cmd_ba    = ba_q;
        cmd_row   = row_q;
        wait_d    = LD_RCD;
        state_d   = ST_COL;
      end
      ST_COL: if (wait_zero) begin
        cmd_valid = 1'b1;
        cmd_type  = is_write(op_q) ? CMD_WR : CMD_RD;
        cmd_bg    = bg_q;
        cmd_ba    = ba_q;
        cmd_col   = col_q;
        wait_d    = is_write(op_q) ? LD_WR : LD_RD;
        state_d   = ST_DATA;
      end
      ST_DATA: if (wait_zero) begin
`ifdef OPEN_PAGE_EN
        done_valid = 1'b1;
        done_op    = op_q;
        state_d    = ST_IDLE;
`else
        state_d    = ST_CLOSE;
`endif
      end
      ST_CLOSE: if (wait_zero && bk_zero) begin
        pre_en     = 1'b1;
        cmd_valid  = 1'b1;
        cmd_type   = CMD_PRE;
        cmd_bg     = bg_q;
        cmd_ba     = ba_q;
        done_valid = 1'b1;
        done_op    = op_q;
        wait_d     = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is a flop so it stays low while reset is held, then tracks IDLE.
  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      op_q    <= '0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      op_q    <= op_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// tb/tb_dram_cmd_issuer.sv - scoreboard bench for dram_cmd_issuer (honours OPEN_PAGE_EN)
module tb_dram_cmd_issuer;

  localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CL = 24, T_CWL = 20, T_BURST = 4;
`ifdef OPEN_PAGE_EN
  localparam bit CLOSE_PAGE = 1'b0;
`else
  localparam bit CLOSE_PAGE = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [32:0] req_addr = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [14:0] cmd_row;
  logic [7:0]  cmd_col;
  logic        done_valid;
  logic [1:0]  done_op;

  dram_cmd_issuer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .done_valid(done_valid), .done_op(done_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 0 = command, 1 = done pulse
    int t;
    int typ;
    int bg;
    int ba;
    int row;
    int col;
    int op;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  bit m_open[16];
  int m_row[16];
  int m_act[16];
  int m_pre[16];

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
      m_act[i]  = -1000;
      m_pre[i]  = -1000;
    end
  endtask

  task automatic push(input int kind, input int t, input int typ, input int bg, input int ba,
                      input int row, input int col, input int op);
    ev_t e;
    e.kind = kind; e.t = t; e.typ = typ; e.bg = bg; e.ba = ba;
    e.row = row; e.col = col; e.op = op;
    exp_q.push_back(e);
  endtask

  // Present a request, wait for acceptance, and queue the sequence it should produce.
  task automatic issue(input int op, input logic [32:0] addr, output int n);
    int bg, ba, row, col, idx, t, pre_t, act_t, col_t, d, cl_t;
    bit got;
    req_op    = 2'(op);
    req_addr  = addr;
    req_valid = 1'b1;
    got = 1'b0;
    n = -1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        n = cyc;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept: req_ready got 0 for 400 cycles, required 1");
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      bg  = int'(addr[7:6]);
      ba  = int'(addr[9:8]);
      row = int'(addr[32:18]);
      col = int'(addr[17:10]);
      idx = bg * 4 + ba;
      t   = n + 2;
      if (m_open[idx] && m_row[idx] == row) begin
        col_t = t;
      end else begin
        if (m_open[idx]) begin
          pre_t = imax(t, m_act[idx] + T_RAS);
          push(0, pre_t, 4, bg, ba, 0, 0, 0);
          m_pre[idx] = pre_t;
          act_t = pre_t + T_RP;
        end else begin
          act_t = imax(t, m_pre[idx] + T_RP);
        end
        push(0, act_t, 1, bg, ba, row, 0, 0);
        m_open[idx] = 1'b1;
        m_row[idx]  = row;
        m_act[idx]  = act_t;
        col_t = act_t + T_RCD;
      end
      push(0, col_t, (op == 1) ? 3 : 2, bg, ba, 0, col, 0);
      d = col_t + ((op == 1) ? T_CWL : T_CL) + T_BURST;
      if (CLOSE_PAGE) begin
        cl_t = imax(d + 1, m_act[idx] + T_RAS);
        push(0, cl_t, 4, bg, ba, 0, 0, 0);
        push(1, cl_t, 0, 0, 0, 0, 0, op);
        m_open[idx] = 1'b0;
        m_pre[idx]  = cl_t;
      end else begin
        push(1, d, 0, 0, 0, 0, 0, op);
      end
    end
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    tests++;
    if (exp_q.size() == 0 || exp_q[0].kind != kind) begin
      fails++;
      $display("FAIL unexpected_%s: cycle %0d got type=%0d bg=%0d ba=%0d op=%0d, required none",
               kind ? "done" : "cmd", cyc, cmd_type, cmd_bg, cmd_ba, done_op);
    end else begin
      e = exp_q.pop_front();
      if (kind == 0) begin
        if (e.t != cyc || e.typ != int'(cmd_type) || e.bg != int'(cmd_bg) || e.ba != int'(cmd_ba) ||
            e.row != int'(cmd_row) || e.col != int'(cmd_col)) begin
          fails++;
          $display("FAIL cmd: got cyc=%0d type=%0d bg=%0d ba=%0d row=%0d col=%0d, required cyc=%0d type=%0d bg=%0d ba=%0d row=%0d col=%0d",
                   cyc, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, e.t, e.typ, e.bg, e.ba, e.row, e.col);
        end
      end else begin
        if (e.t != cyc || e.op != int'(done_op)) begin
          fails++;
          $display("FAIL done: got cyc=%0d op=%0d, required cyc=%0d op=%0d", cyc, done_op, e.t, e.op);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        check_ev(0);
      end else begin
        tests++;
        if (cmd_type != 3'd0) begin
          fails++;
          $display("FAIL nop_type: cycle %0d got cmd_type=%0d, required 0", cyc, cmd_type);
        end
      end
      if (done_valid) check_ev(1);
    end
  end

  initial begin
    int n;
    model_clear();
    @(negedge clk);
    tests++;
    if ({req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, done_valid, done_op} != 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%0d cmd_valid=%0d type=%0d done=%0d, required all 0",
               req_ready, cmd_valid, cmd_type, done_valid);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %0d, required 1", req_ready);
    end
    @(posedge clk);
    #1;

    issue(0, 33'h0_0000_0000, n);   // closed bank: ACT, RD col 0
    issue(0, 33'h0_0000_0000, n);   // same row again
    issue(0, 33'h0_0000_0400, n);   // same bank, col 1
    issue(0, 33'h0_0004_0000, n);   // row 1, bank 0
    issue(1, 33'h0_0000_01C0, n);   // write bg3 ba1
    issue(2, 33'h1_2345_67C0, n);   // fetch, bg3 ba3
    issue(3, 33'h0_0008_0540, n);   // alternate read code, bg1 ba1 row 2 col 1

    issue(0, 33'h0_0000_0200, n);   // bank 2, then reset during COL wait
    while (cyc < n + 12) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, done_valid, done_op} != 35'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got ready=%0d cmd_valid=%0d type=%0d done=%0d, required all 0",
               req_ready, cmd_valid, cmd_type, done_valid);
    end
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    issue(0, 33'h0_0000_0200, n);   // must start again with ACT

    for (int k = 0; k < 600 && exp_q.size() != 0; k++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_cmd_issuer.md
Name: dram_cmd_issuer

Overview:
- Sits directly downstream of the memory-controller request queue.
- Takes one queued request at a time (op code plus 33-bit physical address) and decodes bank group, bank, row and column.
- Tracks open rows for all 16 banks and emits the DDR4 command sequence (PRE/ACT/RD/WR) on a command bus while honouring tRCD, tRP, tRAS, tCL/tCWL and burst timing.
- Pulses completion so the controller can retire the queue entry.

Parameters:
- T_RCD, 24, ACT-to-RD/WR delay in clocks
- T_RP, 24, PRE-to-ACT delay, same bank
- T_RAS, 52, minimum ACT-to-PRE, same bank
- T_CL, 24, RD-to-data latency
- T_CWL, 20, WR-to-data latency
- T_BURST, 4, data burst length in clocks
- CNT_W, 7, timer width; must hold the largest parameter and T_CL+T_BURST

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request available
- req_ready  out  1  issuer can accept a request
- req_op  in  2  0=read, 1=write, 2=fetch, 3=read
- req_addr  in  33  physical address
- cmd_valid  out  1  command issued this cycle
- cmd_type  out  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE
- cmd_bg  out  2  bank group
- cmd_ba  out  2  bank
- cmd_row  out  15  row, ACT only
- cmd_col  out  8  column, RD/WR only
- done_valid  out  1  one-cycle completion pulse
- done_op  out  2  op of the completed request

Behaviour:
- Reset: the block has one clock; reset is asynchronous and active-high. All outputs go to 0 except req_ready=0. All bank open flags are cleared, all timers go to 0, and the FSM enters IDLE. Reset asserted mid-sequence abandons the request with no done pulse.
- Address decode: bg=addr[7:6], ba=addr[9:8], bank index={bg,ba}, row=addr[32:18], col=addr[17:10]. addr[5:0] is ignored.
- Handshake: req_ready=1 only in IDLE. The fields are latched on the cycle req_valid&&req_ready.
- Per-bank state: open flag, open row, and bank_cnt, which counts down to 0 saturating.
  - ACT loads bank_cnt=T_RAS.
  - PRE loads bank_cnt=T_RP.
  - PRE and ACT to a bank require its bank_cnt==0.
- A global wait_cnt is loaded on each command; a state advances only when wait_cnt==0.
- FSM states and transitions:
  - IDLE: on accept, go to DECODE.
  - DECODE: row hit goes to COL; bank closed goes to ACT; bank open with a different row goes to PRE.
  - PRE: when bank_cnt==0, issue PRE, clear the open flag, go to ACT.
  - ACT: when bank_cnt==0, issue ACT, set the open flag and row, load wait_cnt=T_RCD, go to COL.
  - COL: when wait_cnt==0, issue RD (op 0/2/3) or WR (op 1), load wait_cnt=T_CL+T_BURST or T_CWL+T_BURST, go to DATA.
  - DATA: when wait_cnt==0, pulse done_valid, go to IDLE (or to CLOSE, see Optional Feature).
- Command output: cmd_valid is high only in issue cycles. cmd_type=NOP whenever cmd_valid=0. Unused row/col fields drive 0.
- Timing from DECODE: DECODE is the cycle after accept. An ACT or RD/WR issues in the first cycle its constraint permits, which can be the DECODE+1 cycle.
- Worked latency, closed bank: accept at N, ACT at N+2, RD at N+2+T_RCD, done at RD+T_CL+T_BURST.
- Counters decrement every cycle, including the load cycle's successor. Loading value V on cycle C makes the counter 0 at C+V.

Optional Feature:
- Macro: OPEN_PAGE_EN.
- Defined (open-page policy): rows stay open after an access; DATA goes straight to IDLE.
- Undefined (close-page policy): DATA goes to CLOSE. CLOSE waits for bank_cnt==0, then issues PRE, clears the open flag, pulses done_valid in that same cycle, and goes to IDLE. DECODE never sees a row hit.
- The done pulse moves from DATA to CLOSE only when the macro is undefined.

Decomposition:
- Package dram_pkg holds:
  - cmd_type enum
  - op codes
  - address-field bit positions and widths
  - fsm state enum
  - default timing constants
- One natural sub-module: dram_bank_table. It holds 16 entries of open flag, row and bank_cnt, with an update port for ACT/PRE and lookup outputs for the current bank index.

Test Plan:
- Reset, then read addr 0x0 accepted at cycle 0 → ACT(bg0,ba0,row0) at cycle 2, RD col0 at 26, done at 54.
- (OPEN_PAGE_EN) read 0x0, then read 0x400 (same bank, col 1) → second request gives RD 1 cycle after DECODE with no ACT, and done T_CL+T_BURST=28 cycles after RD.
- (OPEN_PAGE_EN) read 0x0, then immediately read 0x40000 (row 1, bank 0) → PRE stalls until bank_cnt expires (ACT+52), ACT at PRE+24, RD at ACT+24.
- Write 0x1C0 (bg3,ba1) → ACT then WR, with done T_CWL+T_BURST=24 cycles after WR and done_op=1.
- (close-page) two reads to the same row → each produces ACT, RD and PRE. The second ACT is not issued earlier than 24 cycles after the first PRE.
- Assert rst during the wait in COL → all outputs 0 at once, no done pulse, and the bank table is cleared (the next access to that bank begins with ACT).
